timer_ctrl: RTL



---
 rtl/timer_ctrl_pkg.sv | 24 ++
 rtl/timer_ctrl_if.sv | 28 ++
 rtl/timer_ctrl_shift_count4.sv | 41 ++++
 rtl/timer_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg
// Shared types and constants for the programmable one-shot timer.
//   state_e          : controller states
//   DEFAULT_PATTERN  : start sequence, first received bit is the MSB
//   SHIFT_LEN        : number of delay bits captured after the pattern
//   tick_width()     : counter width for a modulus, never below 1 bit

package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SHIFT  = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
    localparam int         SHIFT_LEN       = 4;

    function automatic int tick_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if
// Serial input / status bundle of the timer.
//   data      : serial pattern + delay bits (master -> slave)
//   ack       : acknowledge for done         (master -> slave)
//   shift_ena : delay capture window         (slave -> master)
//   counting  : timer running                (slave -> master)
//   done      : timer expired, awaiting ack  (slave -> master)
//   count     : remaining delay units        (slave -> master)
//   timeout   : one-cycle unacknowledged-done pulse, present only when
//               TIMER_CTRL_ACK_TIMEOUT_EN is defined

interface timer_ctrl_if;
    logic       data;
    logic       ack;
    logic       shift_ena;
    logic       counting;
    logic       done;
    logic [3:0] count;
`ifdef TIMER_CTRL_ACK_TIMEOUT_EN
    logic       timeout;

    modport master (output data, ack, input shift_ena, counting, done, count, timeout);
    modport slave  (input data, ack, output shift_ena, counting, done, count, timeout);
`else
    modport master (output data, ack, input shift_ena, counting, done, count);
    modport slave  (input data, ack, output shift_ena, counting, done, count);
`endif
endinterface

// File: rtl/timer_ctrl_shift_count4.sv
// shift_count4
// 4-bit register that either shifts serial data in MSB-first or counts down.
//   clk         : rising-edge clock
//   reset       : synchronous active-high reset, clears q
//   shift_ena_i : shift data_i into the LSB, older bits move toward the MSB
//   count_ena_i : decrement q, saturating at 0
//   data_i      : serial input bit
//   q_o         : register contents

module shift_count4 (
    input  logic       clk,
    input  logic       reset,
    input  logic       shift_ena_i,
    input  logic       count_ena_i,
    input  logic       data_i,
    output logic [3:0] q_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (shift_ena_i) begin
            q_d = {q_q[2:0], data_i};
        end else if (count_ena_i && (q_q != 4'd0)) begin
            q_d = q_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl
// Programmable one-shot timer on a single serial input. Searches for a
// start pattern, captures a 4-bit delay MSB-first, runs for
// (delay+1)*TICKS_PER_COUNT cycles, then holds done until acknowledged.
// Optional feature macro: TIMER_CTRL_ACK_TIMEOUT_EN (adds ACK_TIMEOUT
// parameter and the timeout pulse; DONE gives up after ACK_TIMEOUT cycles).
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : timer_ctrl_if.slave (data, ack in; shift_ena, counting, done,
//           count, [timeout] out)
//
// state  | meaning
// SEARCH | sliding 4-bit window over data, waiting for PATTERN
// SHIFT  | 4 cycles, delay bits shifted into count
// COUNT  | ticking; count decrements each TICKS_PER_COUNT cycles
// DONE   | done held until ack (or timeout when enabled)

module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int         TICKS_PER_COUNT = 1000,
    parameter logic [3:0] PATTERN         = DEFAULT_PATTERN
`ifdef TIMER_CTRL_ACK_TIMEOUT_EN
   ,parameter int         ACK_TIMEOUT     = 64
`endif
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);

    localparam int             TW        = tick_width(TICKS_PER_COUNT);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICKS_PER_COUNT - 1);
    localparam logic [1:0]     PHASE_LAST = 2'(SHIFT_LEN - 1);

    state_e        state_q, state_d;
    // Only the three most recent bits are stored; the live data bit
    // completes the 4-bit match window.
    logic [2:0]    hist_q, hist_d;
    logic [1:0]    phase_q, phase_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          count_ena;
    logic [3:0]    count;
    logic [3:0]    window;

`ifdef TIMER_CTRL_ACK_TIMEOUT_EN
    localparam int            AW       = tick_width(ACK_TIMEOUT);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);

    logic [AW-1:0] ack_tmr_q, ack_tmr_d;
    logic          timeout_q, timeout_d;
`endif

    assign window = {hist_q, bus.data};

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        phase_d   = phase_q;
        tick_d    = tick_q;
        count_ena = 1'b0;
`ifdef TIMER_CTRL_ACK_TIMEOUT_EN
        ack_tmr_d = ack_tmr_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            SEARCH: begin
                hist_d = window[2:0];
                if (window == PATTERN) begin
                    state_d = SHIFT;
                    phase_d = 2'd0;
                end
            end
            SHIFT: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == PHASE_LAST) begin
                    state_d = COUNT;
                    tick_d  = '0;
                end
            end
            COUNT: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (count != 4'd0) begin
                        count_ena = 1'b1;
                    end else begin
                        state_d = DONE;
`ifdef TIMER_CTRL_ACK_TIMEOUT_EN
                        ack_tmr_d = '0;
`endif
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            DONE: begin
                // The history is wiped on exit so stale pattern bits captured
                // before the run can never combine with new ones.
                if (bus.ack) begin
                    state_d = SEARCH;
                    hist_d  = '0;
`ifdef TIMER_CTRL_ACK_TIMEOUT_EN
                end else if (ack_tmr_q == ACK_LAST) begin
                    state_d   = SEARCH;
                    hist_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    ack_tmr_d = ack_tmr_q + AW'(1);
`endif
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEARCH;
            hist_q    <= '0;
            phase_q   <= '0;
            tick_q    <= '0;
`ifdef TIMER_CTRL_ACK_TIMEOUT_EN
            ack_tmr_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            phase_q   <= phase_d;
            tick_q    <= tick_d;
`ifdef TIMER_CTRL_ACK_TIMEOUT_EN
            ack_tmr_q <= ack_tmr_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    shift_count4 u_shift_count4 (
        .clk         (clk),
        .reset       (reset),
        .shift_ena_i (state_q == SHIFT),
        .count_ena_i (count_ena),
        .data_i      (bus.data),
        .q_o         (count)
    );

    assign bus.shift_ena = (state_q == SHIFT);
    assign bus.counting  = (state_q == COUNT);
    assign bus.done      = (state_q == DONE);
    assign bus.count     = count;
`ifdef TIMER_CTRL_ACK_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`endif

endmodule
